hazard_stall_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core. It works alongside the forwarding logic.
- Decides when IF/ID must hold, when ID/EX takes a bubble, and when IF/ID is flushed on a redirect.
- Detects hazards that forwarding cannot cover: load-use, and branch/jr operands compared in ID.
- Sequences the shared multi-cycle mult/div unit: issues its start pulse and interlocks HI/LO consumers until it finishes.

---
 rtl/hazard_stall_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Summary  : Hazard interlock for the 5-stage MIPS pipeline. Covers load-use,
//            ID-stage branch operand hazards and mult/div sequencing with
//            HI/LO consumer interlock.
//            HAZARD_PERF_CNT_EN adds saturating stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_RegisterRs,
    input  logic [4:0]       ID_RegisterRt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_MulDiv,
    input  logic             ID_ReadHiLo,
    input  logic             BranchTaken,
    input  logic             Jump,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_RegWrite,
    input  logic [4:0]       EX_MEM_RegisterRd,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MulDiv_Start,
    output logic             MulDiv_Busy,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] LoadUse_Stalls
);

    localparam logic [7:0] C_MD_LOAD = 8'(MD_LATENCY - 1);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_md_cnt;
    logic [7:0] w_md_cnt_nxt;

    logic w_rs_ex;
    logic w_rt_ex;
    logic w_rs_mem;
    logic w_rt_mem;
    logic w_load_use;
    logic w_br_haz;
    logic w_md_haz;
    logic w_stall;

    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] d);
        return (d != 5'd0) && (d == r);
    endfunction

    assign w_rs_ex  = reg_match(ID_RegisterRs, ID_EX_RegisterRd);
    assign w_rt_ex  = reg_match(ID_RegisterRt, ID_EX_RegisterRd);
    assign w_rs_mem = reg_match(ID_RegisterRs, EX_MEM_RegisterRd);
    assign w_rt_mem = reg_match(ID_RegisterRt, EX_MEM_RegisterRd);

    assign w_load_use = ID_EX_MemRead && ((ID_UsesRs && w_rs_ex) || (ID_UsesRt && w_rt_ex));

    // rt reaches the ID comparator only from MEM/WB, so any MEM-stage write to rt stalls
    assign w_br_haz = ID_Branch && ((ID_EX_RegWrite && (w_rs_ex || w_rt_ex)) ||
                                    (EX_MEM_MemRead && w_rs_mem) ||
                                    (EX_MEM_RegWrite && w_rt_mem));

    assign w_md_haz = (r_state == MD_BUSY) && (ID_MulDiv || ID_ReadHiLo);
    assign w_stall  = w_load_use || w_br_haz || w_md_haz;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= RUN;
            r_md_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        MulDiv_Start = 1'b0;
        MulDiv_Busy  = 1'b0;
        if (reset) begin
            if (w_stall) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end else begin
                IF_ID_Flush = BranchTaken || Jump;
            end
            case (r_state)
                RUN: begin
                    if (ID_MulDiv && !w_stall) begin
                        MulDiv_Start = 1'b1;
                        w_state_nxt  = MD_BUSY;
                        w_md_cnt_nxt = C_MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    MulDiv_Busy = 1'b1;
                    // count of zero marks the final busy cycle
                    if (r_md_cnt == 8'd0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_md_cnt_nxt = r_md_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt  = RUN;
                    w_md_cnt_nxt = 8'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_lu_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_lu_cnt    <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_load_use && (r_lu_cnt != '1)) begin
                r_lu_cnt <= r_lu_cnt + 1'b1;
            end
        end
    end

    assign Stall_Cycles   = r_stall_cnt;
    assign LoadUse_Stalls = r_lu_cnt;
`else
    assign Stall_Cycles   = '0;
    assign LoadUse_Stalls = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Summary  : Scoreboard bench for hazard_stall_ctrl (MD_LATENCY=4, CNT_W=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int MD_LAT = 4;
    localparam int CW     = 3;
    localparam int CMAX   = (1 << CW) - 1;

    typedef struct packed {
        logic [5:0]    ctl;   // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Start, Busy}
        logic [CW-1:0] sc;
        logic [CW-1:0] lu;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs, rt, ex_rd, mem_rd;
    logic          uses_rs, uses_rt, branch, muldiv, readhilo, bt, jump;
    logic          ex_memread, ex_regwrite, mem_memread, mem_regwrite;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, md_start, md_busy;
    logic [CW-1:0] stall_cycles, lu_stalls;

    exp_t  exp_q[$];
    string tag_q[$];
    event  sample_ev;
    int    n_vec = 0;
    int    n_err = 0;
    int    m_left = 0;
    int    m_sc = 0;
    int    m_lu = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .ID_RegisterRs(rs), .ID_RegisterRt(rt),
        .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
        .ID_Branch(branch), .ID_MulDiv(muldiv), .ID_ReadHiLo(readhilo),
        .BranchTaken(bt), .Jump(jump),
        .ID_EX_MemRead(ex_memread), .ID_EX_RegWrite(ex_regwrite), .ID_EX_RegisterRd(ex_rd),
        .EX_MEM_MemRead(mem_memread), .EX_MEM_RegWrite(mem_regwrite), .EX_MEM_RegisterRd(mem_rd),
        .PC_Write(pc_write), .IF_ID_Write(ifid_write), .IF_ID_Flush(ifid_flush),
        .ID_EX_Flush(idex_flush), .MulDiv_Start(md_start), .MulDiv_Busy(md_busy),
        .Stall_Cycles(stall_cycles), .LoadUse_Stalls(lu_stalls)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    initial begin
        exp_t  e;
        string t;
        forever begin
            @(sample_ev);
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val({t, ".ctl"}, 32'({pc_write, ifid_write, ifid_flush, idex_flush, md_start, md_busy}), 32'(e.ctl));
            check_val({t, ".stall_cnt"}, 32'(stall_cycles), 32'(e.sc));
            check_val({t, ".lu_cnt"}, 32'(lu_stalls), 32'(e.lu));
        end
    end

    task automatic idle();
        reset = 1'b1;
        rs = 5'd0; rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        uses_rs = 1'b0; uses_rt = 1'b0; branch = 1'b0; muldiv = 1'b0; readhilo = 1'b0;
        bt = 1'b0; jump = 1'b0;
        ex_memread = 1'b0; ex_regwrite = 1'b0; mem_memread = 1'b0; mem_regwrite = 1'b0;
    endtask

    // Inputs are already driven (just after a falling edge); predict, enqueue, advance one cycle.
    task automatic step(input string tag);
        exp_t e;
        logic lu, bh, mh, st, busy, start;
        busy  = (m_left > 0);
        lu    = ex_memread && ((uses_rs && ex_rd != 0 && ex_rd == rs) ||
                               (uses_rt && ex_rd != 0 && ex_rd == rt));
        bh    = branch && ((ex_regwrite && ex_rd != 0 && (ex_rd == rs || ex_rd == rt)) ||
                           (mem_memread && mem_rd != 0 && mem_rd == rs) ||
                           (mem_regwrite && mem_rd != 0 && mem_rd == rt));
        mh    = busy && (muldiv || readhilo);
        st    = lu || bh || mh;
        start = !busy && muldiv && !st;
        if (!reset) e.ctl = 6'b110000;
        else        e.ctl = {!st, !st, !st && (bt || jump), st, start, busy};
`ifdef HAZARD_PERF_CNT_EN
        e.sc = m_sc[CW-1:0];
        e.lu = m_lu[CW-1:0];
`else
        e.sc = '0;
        e.lu = '0;
`endif
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1 ->sample_ev;
        @(posedge clk);
        if (!reset) begin
            m_left = 0; m_sc = 0; m_lu = 0;
        end else begin
            if (start)     m_left = MD_LAT;
            else if (busy) m_left--;
            if (st && m_sc < CMAX) m_sc++;
            if (lu && m_lu < CMAX) m_lu++;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(negedge clk);
        step("rst0");
        reset = 1'b0; ex_memread = 1'b1; ex_rd = 5'd8; uses_rs = 1'b1; rs = 5'd8; jump = 1'b1; muldiv = 1'b1;
        step("rst_force");
        idle(); step("post_rst");

        // load-use
        idle(); ex_memread = 1'b1; ex_rd = 5'd8; uses_rs = 1'b1; rs = 5'd8; step("lu_rs");
        idle(); uses_rs = 1'b1; rs = 5'd8; step("lu_after");
        idle(); ex_memread = 1'b1; ex_rd = 5'd0; uses_rs = 1'b1; rs = 5'd0; step("lu_rd0");
        idle(); ex_memread = 1'b1; ex_rd = 5'd8; rs = 5'd8; rt = 5'd8; step("lu_nouse");
        idle(); ex_memread = 1'b1; ex_rd = 5'd8; uses_rt = 1'b1; rt = 5'd8; step("lu_rt");

        // branch operands in ID
        idle(); branch = 1'b1; rs = 5'd4; rt = 5'd5; uses_rs = 1'b1; uses_rt = 1'b1;
        ex_regwrite = 1'b1; ex_rd = 5'd5; step("br_ex");
        ex_regwrite = 1'b0; ex_rd = 5'd0; mem_regwrite = 1'b1; mem_rd = 5'd5; step("br_mem_rt");
        mem_regwrite = 1'b0; mem_rd = 5'd0; bt = 1'b1; step("br_taken");
        bt = 1'b0; mem_regwrite = 1'b1; mem_rd = 5'd4; step("br_mem_rs_alu");
        mem_regwrite = 1'b0; mem_memread = 1'b1; mem_rd = 5'd4; step("br_mem_rs_ld");
        mem_rd = 5'd5; step("br_mem_rt_ld_only");

        // mult/div sequencing
        idle(); muldiv = 1'b1; step("md_start");
        idle(); step("md_busy1");
        for (int i = 0; i < 3; i++) begin idle(); readhilo = 1'b1; step("md_mflo_stall"); end
        idle(); readhilo = 1'b1; step("md_mflo_go");
        idle(); muldiv = 1'b1; step("md2_start");
        for (int i = 0; i < 4; i++) begin idle(); muldiv = 1'b1; step("md2_mult_stall"); end
        idle(); muldiv = 1'b1; step("md2_restart");
        for (int i = 0; i < 4; i++) begin idle(); uses_rs = 1'b1; rs = 5'd3; step("md3_indep"); end
        idle(); step("md3_done");

        // stall overrides redirect
        idle(); ex_memread = 1'b1; ex_rd = 5'd8; uses_rs = 1'b1; rs = 5'd8; jump = 1'b1; step("jmp_stall");
        idle(); jump = 1'b1; step("jmp_go");

        // reset abandons an in-flight op
        idle(); muldiv = 1'b1; step("md4_start");
        idle(); step("md4_b1");
        idle(); reset = 1'b0; muldiv = 1'b1; step("md4_rst");
        idle(); step("md4_after");

        // counter saturation
        for (int i = 0; i < 10; i++) begin
            idle(); ex_memread = 1'b1; ex_rd = 5'd9; uses_rt = 1'b1; rt = 5'd9; step("sat");
        end
        idle(); step("sat_end");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            reset        = ($urandom_range(0, 39) != 0);
            rs           = 5'($urandom_range(0, 3));
            rt           = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            uses_rs      = 1'($urandom_range(0, 1));
            uses_rt      = 1'($urandom_range(0, 1));
            branch       = ($urandom_range(0, 3) == 0);
            muldiv       = ($urandom_range(0, 5) == 0);
            readhilo     = ($urandom_range(0, 5) == 0);
            bt           = ($urandom_range(0, 3) == 0);
            jump         = ($urandom_range(0, 5) == 0);
            ex_memread   = 1'($urandom_range(0, 1));
            ex_regwrite  = 1'($urandom_range(0, 1));
            mem_memread  = 1'($urandom_range(0, 1));
            mem_regwrite = 1'($urandom_range(0, 1));
            step("rand");
        end
        idle(); step("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
